// File: rtl/eval_sched_if.sv
// Bundle of request, response, datapath and status signals for eval_sched.
// The slave modport is the scheduler's view; the master modport is the view
// of the surrounding requesters, consumer and datapath.
interface eval_sched_if #(
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req0_kern;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          req1_kern;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_id;

    logic [DW-1:0] eval_a;
    logic [DW-1:0] eval_b;
    logic          eval_kern;
    logic          eval_clk_en;
    logic [DW-1:0] eval_result;

    logic [7:0]    grant_cnt0;
    logic [7:0]    grant_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_kern,
        input  req1_valid, req1_a, req1_b, req1_kern,
        input  rsp_ready, eval_result,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        output eval_a, eval_b, eval_kern, eval_clk_en,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_kern,
        output req1_valid, req1_a, req1_b, req1_kern,
        output rsp_ready, eval_result,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        input  eval_a, eval_b, eval_kern, eval_clk_en,
        input  grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/eval_sched.sv
// Two-requester round-robin scheduler in front of a registered datapath.
// One operation at a time: grant in IDLE, one gated datapath clock in ISSUE,
// hold the result in RESP until the consumer takes it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a valid requester; grant is combinational
// ISSUE    | latched operands on eval_*, datapath clock enabled this cycle
// RESP     | eval_result presented on rsp_data until rsp_ready
module eval_sched #(
    parameter int DW = 8
) (
    input  logic       clk,
    input  logic       rst,
    eval_sched_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ptr_q;
    logic          id_q;
    logic [DW-1:0] a_q, b_q;
    logic          kern_q;
    logic [7:0]    cnt0_q, cnt1_q;
    logic          in_idle, gnt0, gnt1;

    // Grant decode: pointer breaks ties, a lone requester always wins.
    // Gated by rst so no ready leaks out while reset is held.
    always_comb begin
        in_idle = rst && (state_q == ST_IDLE);
        gnt0    = in_idle && bus.req0_valid && (!bus.req1_valid || !ptr_q);
        gnt1    = in_idle && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
    end

    // Next-state: one cycle in ISSUE, RESP waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gnt0 || gnt1) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, operand latch, arbitration pointer and saturating grant counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            kern_q  <= 1'b0;
            cnt0_q  <= 8'd0;
            cnt1_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            if (gnt0 || gnt1) begin
                a_q    <= gnt0 ? bus.req0_a    : bus.req1_a;
                b_q    <= gnt0 ? bus.req0_b    : bus.req1_b;
                kern_q <= gnt0 ? bus.req0_kern : bus.req1_kern;
                id_q   <= gnt1;
                // point at whoever lost (or was absent) this round
                ptr_q  <= gnt0;
            end
            if (gnt0 && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
            if (gnt1 && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    // eval_* come straight from the latch so they only move on a grant;
    // rsp_data is forced to zero outside RESP.
    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.eval_a      = a_q;
    assign bus.eval_b      = b_q;
    assign bus.eval_kern   = kern_q;
    assign bus.eval_clk_en = (state_q == ST_ISSUE);
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_data    = (state_q == ST_RESP) ? bus.eval_result : '0;
    assign bus.rsp_id      = id_q;
    assign bus.grant_cnt0  = cnt0_q;
    assign bus.grant_cnt1  = cnt1_q;
endmodule

// File: tb/tb_eval_sched.sv
// Bench for eval_sched: directed scenarios plus randomized traffic, checked
// against a transaction-level model of arbitration, results and counters.
module tb_eval_sched;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    eval_sched_if #(.DW(DW)) bus ();

    eval_sched #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath stand-in: result register clocked only when enabled.
    logic [DW-1:0] rom [16];
    logic [DW-1:0] dp_q = '0;
    always @(posedge clk)
        if (bus.eval_clk_en)
            dp_q <= bus.eval_a + ~bus.eval_b + (bus.eval_kern ? rom[bus.eval_a[3:0]] : '0);
    assign bus.eval_result = dp_q;

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending operation per requester, pointer, grant counts.
    bit            pv [2];
    logic [DW-1:0] pa [2];
    logic [DW-1:0] pb [2];
    bit            pk [2];
    bit            mptr;
    int            mcnt [2];
    logic [DW-1:0] last_data;
    logic          last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit k);
        logic [DW-1:0] r;
        r = a + ~b;
        if (k) r = r + rom[a[3:0]];
        return r;
    endfunction

    task automatic drive();
        bus.req0_valid = pv[0];
        bus.req0_a     = pa[0];
        bus.req0_b     = pb[0];
        bus.req0_kern  = pk[0];
        bus.req1_valid = pv[1];
        bus.req1_a     = pa[1];
        bus.req1_b     = pb[1];
        bus.req1_kern  = pk[1];
    endtask

    task automatic new_op(input int i);
        pv[i] = 1'b1;
        pa[i] = DW'($urandom);
        pb[i] = DW'($urandom);
        pk[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        drive();
        mptr = 1'b0;
        mcnt[0] = 0;
        mcnt[1] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One full operation starting with the DUT in IDLE.
    task automatic run_op(input int stall, input bit refill);
        int            w;
        logic [DW-1:0] ea, eb, exp_d;
        bit            ek;
        @(negedge clk);
        drive();
        bus.rsp_ready = 1'($urandom_range(0, 1));
        #1;
        w = (pv[0] && pv[1]) ? int'(mptr) : (pv[0] ? 0 : 1);
        chk("grant_req0_ready", bus.req0_ready, w == 0);
        chk("grant_req1_ready", bus.req1_ready, w == 1);
        ea = pa[w];
        eb = pb[w];
        ek = pk[w];
        exp_d = ref_result(ea, eb, ek);
        mptr = (w == 0);
        if (mcnt[w] < 255) mcnt[w]++;
        pv[w] = 1'b0;
        if (refill) new_op(w);

        @(negedge clk);
        drive();
        bus.rsp_ready = 1'($urandom_range(0, 1));
        #1;
        chk("issue_clk_en", bus.eval_clk_en, 1);
        chk("issue_eval_a", bus.eval_a, ea);
        chk("issue_eval_b", bus.eval_b, eb);
        chk("issue_eval_kern", bus.eval_kern, ek);
        chk("issue_req0_ready", bus.req0_ready, 0);
        chk("issue_req1_ready", bus.req1_ready, 0);
        chk("issue_rsp_valid", bus.rsp_valid, 0);

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            bus.rsp_ready = (s == stall);
            #1;
            chk("resp_valid", bus.rsp_valid, 1);
            chk("resp_data", bus.rsp_data, exp_d);
            chk("resp_id", bus.rsp_id, w);
            chk("resp_clk_en", bus.eval_clk_en, 0);
            chk("resp_eval_a_hold", bus.eval_a, ea);
            chk("resp_req0_ready", bus.req0_ready, 0);
            chk("resp_req1_ready", bus.req1_ready, 0);
            chk("resp_cnt0", bus.grant_cnt0, mcnt[0]);
            chk("resp_cnt1", bus.grant_cnt1, mcnt[1]);
        end
        last_data = bus.rsp_data;
        last_id   = bus.rsp_id;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = DW'(i * 11);
        pv[0] = 0; pv[1] = 0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
        pk[0] = 0; pk[1] = 0;
        mptr = 0; mcnt[0] = 0; mcnt[1] = 0;
        bus.rsp_ready = 1'b1;

        // Reset values, with both requesters valid while reset is held.
        rst = 1'b0;
        drive();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_eval_a", bus.eval_a, 0);
        chk("rst_eval_b", bus.eval_b, 0);
        chk("rst_eval_kern", bus.eval_kern, 0);
        chk("rst_clk_en", bus.eval_clk_en, 0);
        chk("rst_cnt0", bus.grant_cnt0, 0);
        chk("rst_cnt1", bus.grant_cnt1, 0);
        do_reset();

        // Kernel op from requester 0, then non-kernel op from requester 1.
        pv[0] = 1; pa[0] = DW'(2); pb[0] = DW'(0); pk[0] = 1;
        run_op(0, 0);
        chk("single_data", last_data, 23);
        chk("single_id", last_id, 0);
        pv[1] = 1; pa[1] = DW'(2); pb[1] = DW'(0); pk[1] = 0;
        run_op(0, 0);
        chk("nokern_data", last_data, 1);
        chk("nokern_id", last_id, 1);
        chk("nokern_cnt1", bus.grant_cnt1, 1);

        // Continuous contention out of reset: strict alternation.
        do_reset();
        new_op(0);
        new_op(1);
        for (int k = 0; k < 4; k++) begin
            run_op(0, 1);
            chk("contend_id", last_id, k % 2);
        end
        chk("contend_cnt0", bus.grant_cnt0, 2);
        chk("contend_cnt1", bus.grant_cnt1, 2);

        // Backpressure with the other requester waiting.
        run_op(5, 1);

        // Reset while holding a response.
        @(negedge clk);
        drive();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst_pre_valid", bus.rsp_valid, 1);
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_cnt0", bus.grant_cnt0, 0);
        chk("midrst_cnt1", bus.grant_cnt1, 0);
        chk("midrst_clk_en", bus.eval_clk_en, 0);
        chk("midrst_req0_ready", bus.req0_ready, 0);
        do_reset();
        new_op(0);
        new_op(1);
        run_op(0, 0);
        chk("midrst_first_id", last_id, 0);
        run_op(0, 0);

        // Randomized traffic, occasional idle cycles and backpressure.
        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i] && $urandom_range(0, 2) != 0) new_op(i);
            if (!pv[0] && !pv[1]) begin
                @(negedge clk);
                drive();
                bus.rsp_ready = 1'($urandom_range(0, 1));
                #1;
                chk("idle_req0_ready", bus.req0_ready, 0);
                chk("idle_req1_ready", bus.req1_ready, 0);
                chk("idle_rsp_valid", bus.rsp_valid, 0);
                chk("idle_clk_en", bus.eval_clk_en, 0);
            end else begin
                run_op($urandom_range(0, 3), 0);
            end
        end

        // Counter saturation.
        do_reset();
        for (int k = 0; k < 260; k++) begin
            new_op(0);
            run_op(0, 0);
        end
        chk("sat_cnt0", bus.grant_cnt0, 255);
        chk("sat_cnt1", bus.grant_cnt1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
